load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage directly downstream of the ALU: ALU result is the effective address of RV32I
//  loads/stores. Generates byte strobes and lane-replicated write data, runs a req/ack handshake to data
//  memory, and returns sign/zero-extended load data. Stalls the single-cycle core until the access retires.
// PARAMETERS
//  XLEN     32   datapath/address width
//  TIMEOUT  255  max REQ cycles waiting for mem_ack before a timeout error; 0 = never time out
// PORTS
//  clk         in   1     clock, rising edge
//  rst_n       in   1     asynchronous active-low reset
//  start       in   1     memory instruction present; held by core while stall=1
//  is_store    in   1     1=store, 0=load
//  funct3      in   3     RV32I width/sign code
//  addr        in   XLEN  effective address (ALU out)
//  store_data  in   XLEN  rs2 value
//  stall       out  1     freeze PC/regfile write
//  done        out  1     1-cycle pulse: access retired (with or without error)
//  err         out  1     1-cycle pulse with done when access failed
//  err_code    out  2     01 misaligned, 10 timeout, 11 illegal funct3; 00 otherwise
//  load_data   out  XLEN  extended load result; held until next load retires
//  mem_req     out  1     request valid
//  mem_we      out  1     write enable
//  mem_addr    out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
//  mem_wstrb   out  4     byte strobes (0000 for loads)
//  mem_wdata   out  XLEN  lane-replicated store data
//  mem_rdata   in   XLEN  read data, valid when mem_ack=1
//  mem_ack     in   1     completes request when sampled with mem_req=1
// BEHAVIOUR
//  Reset: state IDLE; stall, done, err, mem_req, mem_we 0; err_code, mem_addr, mem_wstrb, mem_wdata,
//   load_data, timeout counter all 0. Reset mid-access drops mem_req immediately; memory abandons it.
//  FSM IDLE/REQ/DONE. stall = (IDLE & start) | REQ (combinational). start sampled only in IDLE.
//  IDLE: start & legal & aligned -> REQ; register mem_addr/we/wstrb/wdata; clear counter.
//        start & (illegal | misaligned) -> DONE with err, no memory request. Illegal has priority.
//  REQ: mem_req=1, request fields stable. mem_ack -> DONE, loads latch extracted mem_rdata into load_data.
//       No ack: counter++; TIMEOUT!=0 and counter==TIMEOUT-1 -> DONE, err_code=10, mem_req drops.
//  DONE: done=1 (err per cause), stall=0, core commits this cycle -> IDLE unconditionally.
//  mem_ack outside REQ ignored. Min latency start->done = 2 cycles (ack in first REQ cycle).
//  funct3 loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; else illegal.
//  Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Byte never misaligned.
//  Stores: SB wstrb=0001<<addr[1:0], wdata={4{sd[7:0]}}; SH wstrb=0011<<{addr[1],0}, wdata={2{sd[15:0]}};
//   SW 1111, sd. Loads: lane=mem_rdata>>(8*addr[1:0]) ; LB/LH sign-extend bit7/15, LBU/LHU zero-extend.
//  load_data unchanged by stores and errored accesses; err_code returns to 00 outside DONE.
// STRUCTURE
//  Shared package lsu_pkg: funct3 codes, err_code values, FSM state encoding.
//  Sub-module lsu_align (combinational): legality/misalign check, wstrb/wdata steering, load extraction.
//  Top: FSM, timeout counter, request/result registers.
// TESTING
//  SW addr=0x104 sd=0xDEADBEEF, ack in 1st REQ -> wstrb=1111 wdata=0xDEADBEEF, done at cycle 2, err=0.
//  SB addr=0x103 sd=0x000000A5 -> mem_addr=0x100 wstrb=1000 wdata=0xA5A5A5A5.
//  LB/LBU addr=0x102 rdata=0x12F34567 -> load_data 0xFFFFFFF3 / 0x000000F3; LH addr=0x102 -> 0x000012F3.
//  LW addr=0x101 -> no mem_req, done+err next cycle, err_code=01; funct3=011 -> err_code=11.
//  TIMEOUT=4, no ack -> mem_req 4 cycles, then done+err err_code=10; late ack ignored.
//  rst_n low during REQ -> mem_req/stall 0 asynchronously; after release IDLE, next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// error codes reported with done, and the access FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: funct3 legality and alignment checks, store strobe
// and data replication, and extraction/extension of the addressed load lane.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_is_store,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_illegal,
    output logic            o_misaligned,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_load_data
);

    logic [XLEN-1:0] w_lane;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_illegal    = 1'b0;
        o_misaligned = 1'b0;
        o_wstrb      = 4'b0000;
        o_wdata      = i_store_data;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_wstrb = 4'b0001 << i_off;
                o_wdata = {(XLEN/8){i_store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                o_misaligned = i_off[0];
                o_wstrb      = 4'b0011 << {i_off[1], 1'b0};
                o_wdata      = {(XLEN/16){i_store_data[15:0]}};
            end
            F3_W: begin
                o_misaligned = (i_off != 2'b00);
                o_wstrb      = 4'b1111;
            end
            default: o_illegal = 1'b1;
        endcase
        // Unsigned widths exist only for loads.
        if (i_is_store && (i_funct3 == F3_BU || i_funct3 == F3_HU)) begin
            o_illegal = 1'b1;
        end
        if (!i_is_store) begin
            o_wstrb = 4'b0000;
        end
    end

    assign w_lane = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_load_data = w_lane;
        case (i_ld_funct3)
            F3_B:    o_load_data = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            F3_H:    o_load_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            F3_BU:   o_load_data = {{(XLEN-8){1'b0}}, w_lane[7:0]};
            F3_HU:   o_load_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            default: o_load_data = w_lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: req/ack handshake FSM with timeout, request
// field registers and load result register; stalls the core until retirement.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code,
    output logic [XLEN-1:0] load_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e          r_state, w_next;
    err_code_e       r_err_code;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_addr, r_wdata, r_load_data;
    logic [3:0]      r_wstrb;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;

    logic            w_illegal, w_misaligned, w_timeout;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata, w_load_ext;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_is_store   (is_store),
        .i_funct3     (funct3),
        .i_off        (addr[1:0]),
        .i_store_data (store_data),
        .o_illegal    (w_illegal),
        .o_misaligned (w_misaligned),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .i_ld_funct3  (r_funct3),
        .i_ld_off     (r_off),
        .i_rdata      (mem_rdata),
        .o_load_data  (w_load_ext)
    );

    // Ack in the final allowed cycle still wins over the timeout.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST) && !mem_ack;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (w_illegal || w_misaligned) ? S_DONE : S_REQ;
            S_REQ:   if (mem_ack || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_err_code  <= ERR_NONE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= 4'b0000;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_load_data <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_cnt <= '0;
                    if (w_illegal) begin
                        r_err_code <= ERR_ILLEGAL;
                    end else if (w_misaligned) begin
                        r_err_code <= ERR_MISALIGN;
                    end else begin
                        r_err_code <= ERR_NONE;
                        r_addr     <= {addr[XLEN-1:2], 2'b00};
                        r_we       <= is_store;
                        r_wstrb    <= w_wstrb;
                        r_wdata    <= w_wdata;
                        r_funct3   <= funct3;
                        r_off      <= addr[1:0];
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (!r_we) r_load_data <= w_load_ext;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) r_err_code <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall     = ((r_state == S_IDLE) && start) || (r_state == S_REQ);
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = mem_req && r_we;
    assign mem_addr  = r_addr;
    assign mem_wstrb = r_wstrb;
    assign mem_wdata = r_wdata;
    assign done      = (r_state == S_DONE);
    assign err       = done && (r_err_code != ERR_NONE);
    assign err_code  = done ? r_err_code : ERR_NONE;
    assign load_data = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts strobes,
// replicated data, extended loads, error codes and latency for each access.
module tb_load_store_unit;

    localparam int T = 4;
    localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_store, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, mem_rdata;
    logic        stall, done, err, mem_req, mem_we;
    logic [1:0]  err_code;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  code;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } exp_t;

    // Expectations shared with the compare process.
    logic [31:0] g_exp_addr = '0;
    logic        g_exp_we = 1'b0;
    logic [3:0]  g_exp_wstrb = '0;
    logic [31:0] g_exp_wdata = '0;
    logic [1:0]  g_exp_code = '0;
    logic        g_bad = 1'b0;
    logic [31:0] g_load = '0;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_wstrb;

    load_store_unit #(.XLEN(32), .TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Access semantics stated as sizes, byte offsets and integer arithmetic.
    function automatic exp_t predict(input bit st, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] sd,
                                     input logic [31:0] rd);
        exp_t   e;
        int     size, off;
        bit     sgn, legal;
        longint v, span;
        e = '{2'b00, 4'b0000, 32'h0, 32'h0};
        off = int'(a % 32'd4);
        legal = 1'b1;
        sgn = 1'b0;
        size = 1;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: begin size = 1; legal = !st; end
            3'd5: begin size = 2; legal = !st; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.code = 2'b11;
        end else if (off % size != 0) begin
            e.code = 2'b01;
        end else if (st) begin
            e.wstrb = 4'(((1 << size) - 1) << off);
            if (size == 1)      e.wdata = {24'd0, sd[7:0]} * 32'h0101_0101;
            else if (size == 2) e.wdata = {16'd0, sd[15:0]} * 32'h0001_0001;
            else                e.wdata = sd;
        end else begin
            span = longint'(1) << (8 * size);
            v = longint'(rd >> (8 * off)) % span;
            if (sgn && v >= span / 2) v = v - span;
            e.ldata = 32'(v);
        end
        return e;
    endfunction

    // Compare process: checks every meaningful output each cycle, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("stall", stall, start);
            check("load_data", load_data, g_load);
            if (mem_req) begin
                if (g_bad) check("req_on_error", mem_req, 1'b0);
                check("mem_addr", mem_addr, g_exp_addr);
                check("mem_we", mem_we, g_exp_we);
                check("mem_wstrb", mem_wstrb, g_exp_wstrb);
                if (g_exp_we) check("mem_wdata", mem_wdata, g_exp_wdata);
            end
            if (done) begin
                check("err_code", err_code, g_exp_code);
                check("err", err, g_exp_code != 2'b00);
            end else begin
                check("err_idle", err, 1'b0);
                check("err_code_idle", err_code, 2'b00);
            end
        end
    end

    // One access; ack_delay = REQ cycles before ack (-1 = never ack).
    task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int ack_delay);
        exp_t e;
        bit   bad, tmo, got;
        int   cyc, reqs, lat, nreq;
        e = predict(st, f3, a, sd, rd);
        bad = (e.code != 2'b00);
        tmo = !bad && (ack_delay < 0 || ack_delay >= T);
        lat  = bad ? 1 : (tmo ? T + 1 : ack_delay + 2);
        nreq = bad ? 0 : (tmo ? T : ack_delay + 1);
        @(posedge clk); #1;
        g_exp_addr  = {a[31:2], 2'b00};
        g_exp_we    = st;
        g_exp_wstrb = e.wstrb;
        g_exp_wdata = e.wdata;
        g_exp_code  = tmo ? 2'b10 : e.code;
        g_bad       = bad;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; mem_rdata = rd;
        seen_addr = '0; seen_wstrb = '0; seen_wdata = '0;
        got = 1'b0; cyc = 0; reqs = 0;
        while (!got && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                got = 1'b1;
            end else if (mem_req) begin
                if (reqs == 0) begin
                    seen_addr = mem_addr; seen_wstrb = mem_wstrb; seen_wdata = mem_wdata;
                end
                mem_ack = (reqs == ack_delay);
                reqs++;
            end
        end
        start = 1'b0; mem_ack = 1'b0; mem_rdata = JUNK;
        if (got && !bad && !tmo && !st) g_load = e.ldata;
        check("done_seen", got, 1'b1);
        check("latency", cyc, lat);
        check("req_cycles", reqs, nreq);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; store_data = '0; mem_rdata = JUNK; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 2'b00);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wstrb", mem_wstrb, 4'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        rst_n = 1'b1;

        run(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, JUNK, 0);
        check("sw_wstrb", seen_wstrb, 4'b1111);
        check("sw_wdata", seen_wdata, 32'hDEAD_BEEF);
        run(1'b1, 3'b000, 32'h103, 32'h0000_00A5, JUNK, 1);
        check("sb_addr", seen_addr, 32'h100);
        check("sb_wstrb", seen_wstrb, 4'b1000);
        check("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
        run(1'b1, 3'b001, 32'h102, 32'h1234_BEEF, JUNK, 0);
        check("sh_wstrb", seen_wstrb, 4'b1100);
        check("sh_wdata", seen_wdata, 32'hBEEF_BEEF);
        run(1'b1, 3'b000, 32'h101, 32'h0000_0077, JUNK, 2);

        run(1'b0, 3'b000, 32'h102, 32'h0, 32'h12F3_4567, 0);
        check("lb_value", load_data, 32'hFFFF_FFF3);
        run(1'b0, 3'b100, 32'h102, 32'h0, 32'h12F3_4567, 1);
        check("lbu_value", load_data, 32'h0000_00F3);
        run(1'b0, 3'b001, 32'h102, 32'h0, 32'h12F3_4567, 0);
        check("lh_value", load_data, 32'h0000_12F3);
        run(1'b0, 3'b001, 32'h100, 32'h0, 32'h1234_8001, 0);
        check("lh_neg_value", load_data, 32'hFFFF_8001);
        run(1'b0, 3'b101, 32'h100, 32'h0, 32'h1234_8001, 2);
        check("lhu_value", load_data, 32'h0000_8001);

        run(1'b0, 3'b010, 32'h101, 32'h0, 32'hFFFF_FFFF, 0);
        check("lw_misalign_keeps_load", load_data, 32'h0000_8001);
        run(1'b0, 3'b011, 32'h100, 32'h0, JUNK, 0);
        run(1'b1, 3'b001, 32'h101, 32'h1111_1111, JUNK, 0);
        run(1'b1, 3'b100, 32'h100, 32'h1111_1111, JUNK, 0);
        run(1'b1, 3'b110, 32'h101, 32'h1111_1111, JUNK, 0);

        run(1'b0, 3'b010, 32'h10C, 32'h0, 32'h7777_7777, -1);
        mem_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("late_ack_req", mem_req, 1'b0);
            check("late_ack_done", done, 1'b0);
        end
        mem_ack = 1'b0;
        run(1'b1, 3'b010, 32'h110, 32'h0BAD_F00D, JUNK, T - 1);
        run(1'b0, 3'b010, 32'h114, 32'h0, 32'h8765_4321, 0);
        check("lw_value", load_data, 32'h8765_4321);

        @(posedge clk); #1;
        g_exp_addr = 32'h200; g_exp_we = 1'b0; g_exp_wstrb = 4'b0000;
        g_exp_code = 2'b00; g_bad = 1'b0;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk); #1;
        check("pre_rst_req", mem_req, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0; start = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 1'b0);
        check("arst_stall", stall, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_load_data", load_data, 32'h0);
        g_load = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(1'b0, 3'b010, 32'h108, 32'h0, 32'hCAFE_F00D, 1);
        check("post_rst_lw", load_data, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
